// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the instruction-fetch / data-memory arbiter.
//   - arb_state_e      : arbiter FSM state encoding
//   - TimeoutDefault   : default cycles to wait for ram_ack before aborting
//   - FairLimitDefault : default consecutive MEM grants allowed while IF waits
//   - word_align()     : clears the byte offset of an address

package mem_arbiter_pkg;

  localparam int unsigned TimeoutDefault   = 255;
  localparam int unsigned FairLimitDefault = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIfBusy  = 2'd1,
    StMemBusy = 2'd2
  } arb_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// mem_byte_lane
//   Purely combinational byte-lane steering for the data port.
//   Store side (driven from the live EX/MEM fields at grant time):
//     st_bw_i     : 1 = byte store, 0 = word store
//     st_lo_i     : address bits [1:0]
//     st_wdata_i  : store data from the pipeline
//     st_be_o     : byte enables (one-hot for byte, all ones for word)
//     st_data_o   : write data (low byte replicated on all lanes for byte)
//   Load side (driven from the offset captured at grant time):
//     ld_bw_i     : 1 = byte load, 0 = word load
//     ld_lo_i     : address bits [1:0] of the access in flight
//     ld_raw_i    : raw word returned by the RAM
//     ld_data_o   : zero-extended byte or full word

module mem_byte_lane (
  input  logic        st_bw_i,
  input  logic [1:0]  st_lo_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_data_o,
  input  logic        ld_bw_i,
  input  logic [1:0]  ld_lo_i,
  input  logic [31:0] ld_raw_i,
  output logic [31:0] ld_data_o
);

  always_comb begin
    st_be_o   = 4'b1111;
    st_data_o = st_wdata_i;
    if (st_bw_i) begin
      st_be_o   = 4'b0001 << st_lo_i;
      // Replicating the byte lets the RAM pick it up on whichever lane is enabled.
      st_data_o = {4{st_wdata_i[7:0]}};
    end
  end

  always_comb begin
    ld_data_o = ld_raw_i;
    if (ld_bw_i) begin
      unique case (ld_lo_i)
        2'd0:    ld_data_o = {24'h0, ld_raw_i[7:0]};
        2'd1:    ld_data_o = {24'h0, ld_raw_i[15:8]};
        2'd2:    ld_data_o = {24'h0, ld_raw_i[23:16]};
        2'd3:    ld_data_o = {24'h0, ld_raw_i[31:24]};
        default: ld_data_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported RAM between the instruction fetch (IF) port and the
//   data (MEM) port of the pipeline. Exactly one RAM access is outstanding at a
//   time. MEM normally wins contention; after FAIR_LIMIT consecutive MEM grants
//   with IF waiting, IF is forced through. An access that sees no ram_ack within
//   TIMEOUT busy cycles is aborted: the requester gets a ready pulse with data 0
//   and the sticky err flag is set until reset.
//
//   Parameters
//     TIMEOUT    : busy cycles without ram_ack before the access is aborted
//     FAIR_LIMIT : consecutive MEM grants with IF waiting before IF is forced
//   Ports
//     clk, rst                 : clock, synchronous active-high reset
//     if_req, if_addr          : fetch request and address
//     if_rdata, if_ready       : fetched word, one-cycle completion pulse
//     MemRead, MemWrite, BW    : data request type, BW = byte access
//     mem_addr, mem_wdata      : EX/MEM ALU result and store data
//     mem_rdata, mem_ready     : load data, one-cycle completion pulse
//     ram_*                    : registered RAM request, held until ram_ack
//     ram_rdata, ram_ack       : RAM response
//     stall_pipe               : freezes EX/MEM and earlier registers
//     stall_if                 : freezes PC/IF
//     err                      : sticky timeout flag

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT    = TimeoutDefault,
  parameter int unsigned FAIR_LIMIT = FairLimitDefault
) (
  input  logic        clk,
  input  logic        rst,
  // Instruction fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  // Data memory port
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        BW,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  // RAM port
  output logic        ram_req,
  output logic        ram_we,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  // Pipeline control
  output logic        stall_pipe,
  output logic        stall_if,
  output logic        err
);

  // The wait counter only needs to reach TIMEOUT-1: the abort happens on the
  // edge that would otherwise count the TIMEOUT-th unanswered busy cycle.
  localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  localparam int unsigned FairW = (FAIR_LIMIT > 0) ? $clog2(FAIR_LIMIT + 1) : 1;
  localparam logic [FairW-1:0] FairMax = FairW'(FAIR_LIMIT);

  arb_state_e       state_q;
  logic [FairW-1:0] fair_q;
  logic [WaitW-1:0] wait_q;
  logic             ld_bw_q;
  logic [1:0]       ld_lo_q;

  logic        mem_req;
  logic        mem_wins;
  logic        access_done;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [31:0] ld_data;

  assign mem_req  = MemRead | MemWrite;
  // MEM has priority unless IF has been starved for FAIR_LIMIT grants.
  assign mem_wins = mem_req && (!if_req || (fair_q != FairMax));

  // Either a real acknowledge or the wait budget running out ends the access.
  assign access_done = ram_ack || (wait_q == WaitLast);

  assign stall_pipe = mem_req & ~mem_ready;
  assign stall_if   = (if_req & ~if_ready) | stall_pipe;

  mem_byte_lane u_byte_lane (
    .st_bw_i    (BW),
    .st_lo_i    (mem_addr[1:0]),
    .st_wdata_i (mem_wdata),
    .st_be_o    (st_be),
    .st_data_o  (st_data),
    .ld_bw_i    (ld_bw_q),
    .ld_lo_i    (ld_lo_q),
    .ld_raw_i   (ram_rdata),
    .ld_data_o  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      fair_q    <= '0;
      wait_q    <= '0;
      ld_bw_q   <= 1'b0;
      ld_lo_q   <= 2'b00;
      err       <= 1'b0;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_be    <= 4'b0000;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
    end else begin
      // Ready outputs are single-cycle pulses.
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (mem_wins) begin
            state_q   <= StMemBusy;
            wait_q    <= '0;
            ram_req   <= 1'b1;
            ram_we    <= MemWrite;
            ram_be    <= st_be;
            ram_addr  <= word_align(mem_addr);
            ram_wdata <= MemWrite ? st_data : '0;
            ld_bw_q   <= BW;
            ld_lo_q   <= mem_addr[1:0];
            // With IF waiting, MEM only wins below FairMax, so this cannot overflow.
            fair_q    <= if_req ? fair_q + FairW'(1) : '0;
          end else if (if_req) begin
            state_q   <= StIfBusy;
            wait_q    <= '0;
            ram_req   <= 1'b1;
            ram_we    <= 1'b0;
            ram_be    <= 4'b1111;
            ram_addr  <= word_align(if_addr);
            ram_wdata <= '0;
            fair_q    <= '0;
          end
        end

        StIfBusy, StMemBusy: begin
          if (access_done) begin
            state_q <= StIdle;
            ram_req <= 1'b0;
            if (!ram_ack) begin
              err <= 1'b1;
            end
            if (state_q == StIfBusy) begin
              if_ready <= 1'b1;
              if_rdata <= ram_ack ? ram_rdata : '0;
            end else begin
              mem_ready <= 1'b1;
              if (!ram_ack) begin
                mem_rdata <= '0;
              end else if (!ram_we) begin
                mem_rdata <= ld_data;
              end
            end
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end

        default: begin
          state_q <= StIdle;
          ram_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. A transaction-level model tracks which
//   requester owns the RAM, predicts grant winners from the fairness rule, the
//   RAM request fields from the requester's fields, and the completion data.
//   Directed scenarios cover word/byte loads, byte stores, contention, timeout
//   and reset mid-access; a long randomized run follows.

module tb_mem_arbiter;

  localparam int unsigned To = 8;
  localparam int unsigned Fl = 4;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        MemRead;
  logic        MemWrite;
  logic        BW;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        ram_req;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;
  logic        stall_pipe;
  logic        stall_if;
  logic        err;

  mem_arbiter #(
    .TIMEOUT    (To),
    .FAIR_LIMIT (Fl)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_ready   (if_ready),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .BW         (BW),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .ram_req    (ram_req),
    .ram_we     (ram_we),
    .ram_be     (ram_be),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .ram_ack    (ram_ack),
    .stall_pipe (stall_pipe),
    .stall_if   (stall_if),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Reference model state
  bit          m_busy;
  int          m_who;      // 0 = IF owns the RAM, 1 = MEM owns it
  int          m_wait;
  int          m_streak;   // MEM grants in a row while IF was waiting
  bit          m_err;
  bit          e_if_rdy;
  bit          e_mem_rdy;
  bit          e_mem_chk;
  logic [31:0] e_if_data;
  logic [31:0] e_mem_data;
  bit          g_we;
  bit          g_bw;
  logic [1:0]  g_lo;
  logic [31:0] g_addr;
  logic [31:0] g_wd;
  logic [3:0]  g_be;
  bit          new_grant;

  // RAM responder and requester policy
  int          lat;
  int          acnt;
  int          force_lat;     // -1 = random latency, 99 = never acknowledge
  int          idle_ack_mode; // 0 = random, 1 = always high
  bit          fix_rd_en;
  logic [31:0] fix_rd;
  bit          auto_if;
  bit          auto_mem;
  bit          keep_if;
  bit          keep_mem;
  bit          log_en;
  bit          prev_req;
  int          glog[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic new_if();
    if_req  = 1'b1;
    if_addr = 32'h1000 + ($urandom_range(255, 0) << 2) + $urandom_range(3, 0);
  endtask

  task automatic new_mem();
    int r;
    r         = $urandom_range(2, 0);
    MemRead   = (r != 1);
    MemWrite  = (r != 0);
    BW        = 1'($urandom_range(1, 0));
    mem_addr  = 32'h8000 + $urandom_range(4095, 0);
    mem_wdata = $urandom();
  endtask

  // One clock cycle: predict from current inputs, clock, compare, drive next inputs.
  task automatic step();
    bit mreq;
    mreq      = MemRead | MemWrite;
    e_if_rdy  = 1'b0;
    e_mem_rdy = 1'b0;
    new_grant = 1'b0;
    if (rst) begin
      m_busy   = 1'b0;
      m_streak = 0;
      m_err    = 1'b0;
    end else if (m_busy) begin
      if (ram_ack || (m_wait == To - 1)) begin
        m_busy = 1'b0;
        if (m_who == 0) begin
          e_if_rdy  = 1'b1;
          e_if_data = ram_ack ? ram_rdata : 32'h0;
        end else begin
          e_mem_rdy  = 1'b1;
          e_mem_chk  = !ram_ack || !g_we;
          e_mem_data = !ram_ack ? 32'h0 :
                       g_bw ? ((ram_rdata >> (8 * g_lo)) & 32'hff) : ram_rdata;
        end
        if (!ram_ack) m_err = 1'b1;
      end else begin
        m_wait++;
      end
    end else if (mreq || if_req) begin
      m_busy    = 1'b1;
      m_wait    = 0;
      new_grant = 1'b1;
      if (mreq && !(if_req && m_streak == Fl)) begin
        m_who    = 1;
        m_streak = if_req ? ((m_streak < Fl) ? m_streak + 1 : Fl) : 0;
        g_we     = MemWrite;
        g_bw     = BW;
        g_lo     = mem_addr[1:0];
        g_addr   = mem_addr & ~32'h3;
        g_be     = BW ? (4'b0001 << mem_addr[1:0]) : 4'hf;
        g_wd     = BW ? {4{mem_wdata[7:0]}} : mem_wdata;
      end else begin
        m_who    = 0;
        m_streak = 0;
        g_we     = 1'b0;
        g_bw     = 1'b0;
        g_lo     = 2'b00;
        g_addr   = if_addr & ~32'h3;
        g_be     = 4'hf;
      end
    end

    @(posedge clk);
    #1;

    check("ram_req", 32'(ram_req), 32'(m_busy));
    if (m_busy) begin
      check("ram_we", 32'(ram_we), 32'(g_we));
      check("ram_addr", ram_addr, g_addr);
      check("ram_be", 32'(ram_be), 32'(g_be));
      if (g_we) check("ram_wdata", ram_wdata, g_wd);
    end
    check("if_ready", 32'(if_ready), 32'(e_if_rdy));
    check("mem_ready", 32'(mem_ready), 32'(e_mem_rdy));
    if (e_if_rdy) check("if_rdata", if_rdata, e_if_data);
    if (e_mem_rdy && e_mem_chk) check("mem_rdata", mem_rdata, e_mem_data);
    check("err", 32'(err), 32'(m_err));

    if (log_en && ram_req && !prev_req) glog.push_back((ram_addr >= 32'h8000) ? 1 : 0);
    prev_req = ram_req;

    // Requesters hold until their completion pulse, then drop or re-request.
    if (e_if_rdy) if_req = 1'b0;
    if (!if_req && (keep_if || (auto_if && $urandom_range(1, 0) == 1))) new_if();
    if (e_mem_rdy) begin
      MemRead  = 1'b0;
      MemWrite = 1'b0;
    end
    if (!(MemRead | MemWrite) && (keep_mem || (auto_mem && $urandom_range(1, 0) == 1))) begin
      new_mem();
    end

    if (m_busy) begin
      if (new_grant) begin
        acnt = 0;
        if (force_lat >= 0) lat = force_lat;
        else lat = ($urandom_range(7, 0) == 0) ? 99 : int'($urandom_range(3, 0));
      end
      ram_ack = (acnt == lat);
      acnt++;
    end else begin
      ram_ack = (idle_ack_mode == 1) ? 1'b1 : ($urandom_range(3, 0) == 0);
    end
    ram_rdata = fix_rd_en ? fix_rd : $urandom();

    #1;
    check("stall_pipe", 32'(stall_pipe), 32'((MemRead | MemWrite) & ~e_mem_rdy));
    check("stall_if", 32'(stall_if),
          32'((if_req & ~e_if_rdy) | ((MemRead | MemWrite) & ~e_mem_rdy)));
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    if_req   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    BW       = 1'b0;
    auto_if  = 1'b0;
    auto_mem = 1'b0;
    keep_if  = 1'b0;
    keep_mem = 1'b0;
    step();
    rst = 1'b0;
    check("rst_ram_req", 32'(ram_req), 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_ram_be", 32'(ram_be), 32'h0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("rst_if_ready", 32'(if_ready), 32'h0);
    check("rst_mem_ready", 32'(mem_ready), 32'h0);
    check("rst_err", 32'(err), 32'h0);
  endtask

  task automatic wait_mem();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      seen = mem_ready;
    end
    if (!seen) check("mem_ready_wait", 32'h0, 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int to_cnt;
    bit seen;
    n_chk         = 0;
    n_fail        = 0;
    rst           = 1'b1;
    if_req        = 1'b0;
    if_addr       = '0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    BW            = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    ram_ack       = 1'b0;
    ram_rdata     = '0;
    force_lat     = -1;
    idle_ack_mode = 0;
    fix_rd_en     = 1'b0;
    fix_rd        = '0;
    log_en        = 1'b0;
    prev_req      = 1'b0;
    m_busy        = 1'b0;
    m_who         = 0;
    m_wait        = 0;
    m_streak      = 0;
    m_err         = 1'b0;
    e_mem_chk     = 1'b0;
    lat           = 0;
    acnt          = 0;
    #2;
    do_reset();

    // Word load, ack two cycles after ram_req.
    MemRead   = 1'b1;
    mem_addr  = 32'h104;
    force_lat = 2;
    fix_rd_en = 1'b1;
    fix_rd    = 32'hDEADBEEF;
    step();
    check("wload_addr", ram_addr, 32'h104);
    check("wload_stall", 32'(stall_pipe), 32'h1);
    wait_mem();
    check("wload_data", mem_rdata, 32'hDEADBEEF);
    step();

    // Byte store.
    MemWrite  = 1'b1;
    BW        = 1'b1;
    mem_addr  = 32'h203;
    mem_wdata = 32'h000000A5;
    force_lat = 1;
    step();
    check("bstore_be", 32'(ram_be), 32'h8);
    check("bstore_wdata", ram_wdata, 32'hA5A5A5A5);
    check("bstore_addr", ram_addr, 32'h200);
    check("bstore_we", 32'(ram_we), 32'h1);
    wait_mem();
    step();

    // Byte load.
    MemRead   = 1'b1;
    BW        = 1'b1;
    mem_addr  = 32'h101;
    force_lat = 0;
    fix_rd    = 32'h11223344;
    wait_mem();
    check("bload_data", mem_rdata, 32'h00000033);
    fix_rd_en = 1'b0;

    // Contention with immediate ack: four MEM grants then one IF grant.
    do_reset();
    force_lat = 0;
    keep_if   = 1'b1;
    keep_mem  = 1'b1;
    log_en    = 1'b1;
    new_if();
    new_mem();
    for (int i = 0; i < 40; i++) step();
    keep_if  = 1'b0;
    keep_mem = 1'b0;
    log_en   = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("fair_count", 32'(glog.size() >= 15), 32'h1);
    for (int i = 0; i < 15 && i < glog.size(); i++) begin
      check($sformatf("fair_seq%0d", i), 32'(glog[i]), (i % 5 == 4) ? 32'h0 : 32'h1);
    end

    // Timeout: no ack at all.
    do_reset();
    MemRead   = 1'b1;
    BW        = 1'b0;
    mem_addr  = 32'h300;
    force_lat = 99;
    to_cnt    = 0;
    seen      = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (ram_req) to_cnt++;
      seen = mem_ready;
    end
    check("to_seen", 32'(seen), 32'h1);
    check("to_cycles", 32'(to_cnt), 32'(To));
    check("to_data", mem_rdata, 32'h0);
    check("to_err", 32'(err), 32'h1);
    for (int i = 0; i < 3; i++) step();
    check("to_err_sticky", 32'(err), 32'h1);

    // Reset in the middle of a MEM access, acknowledge arriving afterwards.
    do_reset();
    MemRead   = 1'b1;
    mem_addr  = 32'h404;
    force_lat = 99;
    step();
    step();
    check("mid_busy", 32'(ram_req), 32'h1);
    idle_ack_mode = 1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_no_ready", 32'(mem_ready), 32'h0);
    end
    idle_ack_mode = 0;
    MemRead   = 1'b1;
    mem_addr  = 32'h400;
    force_lat = 1;
    fix_rd_en = 1'b1;
    fix_rd    = 32'hCAFEF00D;
    wait_mem();
    check("mid_next_data", mem_rdata, 32'hCAFEF00D);
    fix_rd_en = 1'b0;

    // Randomized traffic.
    do_reset();
    force_lat = -1;
    auto_if   = 1'b1;
    auto_mem  = 1'b1;
    for (int i = 0; i < 3000; i++) step();
    auto_if  = 1'b0;
    auto_mem = 1'b0;
    for (int i = 0; i < 40; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
